// File: rtl/adam_axil_pkg.sv
// Shared AXI-Lite response codes, bridge FSM states and small helpers for the
// OBI-to-AXI-Lite multiple-outstanding bridge.
package adam_axil_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } bridge_state_e;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Any response code with the error bit set (SLVERR, DECERR) is an OBI error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (axi_resp_e'(resp) == AXI_RESP_SLVERR) ||
           (axi_resp_e'(resp) == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/adam_obi_axil_ctr.sv
// Outstanding-transaction counter: up on grant, down on response, never wraps.
module adam_obi_axil_ctr #(
  parameter int unsigned  MAX_VAL = 4,
  localparam int unsigned CW      = $clog2(MAX_VAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic empty_nxt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Simultaneous inc/dec cancel; inc at max and dec at zero are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CW'(MAX_VAL))) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o      = (cnt_q == CW'(MAX_VAL));
  assign empty_o     = (cnt_q == '0);
  assign empty_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/adam_obi_to_axil_mo.sv
// OBI slave to AXI-Lite master bridge with up to MAX_TRANS same-direction
// transactions in flight and a drain-then-pause handshake.
module adam_obi_to_axil_mo
  import adam_axil_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH = 32,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  MAX_TRANS  = 4,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  pause_req,
  output logic                  pause_ack,

  input  logic                  req,
  output logic                  gnt,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,

  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,

  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [2:0]            aw_prot,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,

  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [2:0]            ar_prot,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  bridge_state_e         state_q, state_d;
  logic                  pause_ack_q, pause_ack_d;
  logic                  dir_q, dir_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic cnt_full, cnt_empty, cnt_empty_nxt;
  logic req_pending, sel_valid, grant, rsp_fire;

  adam_obi_axil_ctr #(
    .MAX_VAL (MAX_TRANS)
  ) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (grant),
    .dec_i       (rsp_fire),
    .full_o      (cnt_full),
    .empty_o     (cnt_empty),
    .empty_nxt_o (cnt_empty_nxt)
  );

  // A new request waits for the previous address/data beats to leave.
  assign req_pending = aw_valid_q || w_valid_q || ar_valid_q;
  assign gnt = req && (state_q == ST_RUN) && !cnt_full && !req_pending &&
               (cnt_empty || (we == dir_q));
  assign grant = gnt;

  // Response path is a pass-through of the channel matching the current direction.
  assign sel_valid = dir_q ? b_valid : r_valid;
  assign rvalid    = !cnt_empty && sel_valid;
  assign b_ready   = dir_q && !cnt_empty && rready;
  assign r_ready   = !dir_q && !cnt_empty && rready;
  assign rdata     = (rvalid && !dir_q) ? r_data : '0;
  assign err       = rvalid && resp_is_err(dir_q ? b_resp : r_resp);
  assign rsp_fire  = rvalid && rready;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;

    if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
    if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
    if (ar_valid_q && ar_ready) ar_valid_d = 1'b0;

    if (grant) begin
      dir_d      = we;
      addr_d     = addr;
      be_d       = be;
      wdata_d    = wdata;
      aw_valid_d = we;
      w_valid_d  = we;
      ar_valid_d = !we;
    end

    // Pause only once everything in flight has fully retired.
    unique case (state_q)
      ST_RUN: begin
        if (pause_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pause_req) begin
          state_d = ST_RUN;
        end else if (cnt_empty_nxt && !aw_valid_d && !w_valid_d && !ar_valid_d) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!pause_req) state_d = ST_RUN;
      end
      default: state_d = ST_PAUSED;
    endcase

    pause_ack_d = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_PAUSED;
      pause_ack_q <= 1'b1;
      dir_q       <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pause_ack_q <= pause_ack_d;
      dir_q       <= dir_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      ar_valid_q  <= ar_valid_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  assign pause_ack = pause_ack_q;
  assign aw_addr   = addr_q;
  assign ar_addr   = addr_q;
  assign aw_prot   = AXI_PROT_DEFAULT;
  assign ar_prot   = AXI_PROT_DEFAULT;
  assign aw_valid  = aw_valid_q;
  assign w_valid   = w_valid_q;
  assign ar_valid  = ar_valid_q;
  assign w_data    = wdata_q;
  assign w_strb    = be_q;

endmodule

// File: tb/tb_adam_obi_to_axil_mo.sv
// Bench for the OBI-to-AXI-Lite bridge: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_adam_obi_to_axil_mo;

  localparam int MAXT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, pause_req = 1'b0, pause_ack;
  logic        req = 1'b0, gnt, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        rvalid, rready = 1'b0, err;
  logic [31:0] rdata;
  logic [31:0] aw_addr, ar_addr, w_data;
  logic [2:0]  aw_prot, ar_prot;
  logic        aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic        b_valid = 1'b0, b_ready, ar_valid, ar_ready = 1'b0;
  logic [31:0] r_data = '0;
  logic        r_valid = 1'b0, r_ready;

  adam_obi_to_axil_mo #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  int checks = 0, errors = 0;

  // Transaction-level model: mode 0 run, 1 draining, 2 paused.
  int          m_mode = 2, m_out = 0, m_rsp = 0;
  bit          m_dir = 0, m_awp = 0, m_wp = 0, m_arp = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;

  // AXI slave bookkeeping (handshake counts seen on the bus).
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
  bit b_hs = 0, r_hs = 0, last_gnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit busy, e_gnt, e_rv, e_br, e_rr, e_err;
    logic [1:0]  sresp;
    logic [31:0] e_rd;
    busy  = m_awp || m_wp || m_arp;
    e_gnt = req && (m_mode == 0) && (m_out < MAXT) && !busy && (m_out == 0 || we == m_dir);
    e_rv  = (m_out > 0) && (m_dir ? b_valid : r_valid);
    e_br  = m_dir && (m_out > 0) && rready;
    e_rr  = !m_dir && (m_out > 0) && rready;
    sresp = m_dir ? b_resp : r_resp;
    e_err = e_rv && (sresp >= 2'd2);
    e_rd  = (e_rv && !m_dir) ? r_data : 32'h0;
    chk("gnt", gnt, e_gnt);
    chk("rvalid", rvalid, e_rv);
    chk("b_ready", b_ready, e_br);
    chk("r_ready", r_ready, e_rr);
    chk("rdata", rdata, e_rd);
    chk("err", err, e_err);
    chk("pause_ack", pause_ack, m_mode == 2);
    chk("aw_valid", aw_valid, m_awp);
    chk("w_valid", w_valid, m_wp);
    chk("ar_valid", ar_valid, m_arp);
    chk("aw_addr", aw_addr, m_addr);
    chk("ar_addr", ar_addr, m_addr);
    chk("w_data", w_data, m_wdata);
    chk("w_strb", w_strb, m_be);
    chk("prot", {aw_prot, ar_prot}, 6'b0);

    b_hs = b_valid && b_ready;
    r_hs = r_valid && r_ready;
    if (aw_valid && aw_ready) n_aw++;
    if (w_valid && w_ready) n_w++;
    if (ar_valid && ar_ready) n_ar++;
    if (b_hs) n_b++;
    if (r_hs) n_r++;
    last_gnt = gnt;

    if (!rst_n) begin
      m_mode = 2; m_out = 0; m_dir = 0; m_awp = 0; m_wp = 0; m_arp = 0;
      m_addr = '0; m_wdata = '0; m_be = '0;
      n_aw = 0; n_w = 0; n_ar = 0; n_b = 0; n_r = 0; b_hs = 0; r_hs = 0;
    end else begin
      if (e_rv && rready) begin m_out--; m_rsp++; end
      if (m_awp && aw_ready) m_awp = 0;
      if (m_wp && w_ready) m_wp = 0;
      if (m_arp && ar_ready) m_arp = 0;
      if (e_gnt) begin
        m_out++; m_dir = we; m_awp = we; m_wp = we; m_arp = !we;
        m_addr = addr; m_wdata = wdata; m_be = be;
      end
      busy = m_awp || m_wp || m_arp;
      case (m_mode)
        0: if (pause_req) m_mode = 1;
        1: if (!pause_req) m_mode = 0; else if (m_out == 0 && !busy) m_mode = 2;
        default: if (!pause_req) m_mode = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Well-behaved AXI-Lite slave; responses only for accepted requests.
  task automatic slave_drive(input bit rnd);
    int owed;
    aw_ready = rnd ? 1'($urandom % 2) : 1'b1;
    w_ready  = rnd ? 1'($urandom % 2) : 1'b1;
    ar_ready = rnd ? 1'($urandom % 2) : 1'b1;
    if (!b_valid || b_hs) begin
      owed    = ((n_aw < n_w) ? n_aw : n_w) - n_b;
      b_valid = (owed > 0) && (rnd ? ($urandom % 2 == 0) : 1'b1);
      b_resp  = 2'($urandom);
    end
    if (!r_valid || r_hs) begin
      owed    = n_ar - n_r;
      r_valid = (owed > 0) && (rnd ? ($urandom % 2 == 0) : 1'b1);
      r_resp  = 2'($urandom);
      r_data  = $urandom;
    end
  endtask

  task automatic drain();
    int budget = 200;
    req = 1'b0;
    rready = 1'b1;
    while ((m_out > 0 || m_awp || m_wp || m_arp) && budget > 0) begin
      slave_drive(1'b0);
      cycle();
      budget--;
    end
    b_valid = 1'b0;
    r_valid = 1'b0;
    chk("drain_outstanding", m_out, 0);
  endtask

  initial begin
    int grants, budget;
    @(posedge clk); #1;
    cycle(); cycle();

    // Reset values, with stimulus that would otherwise produce activity.
    req = 1'b1; r_valid = 1'b1; r_data = 32'hCAFE0001; r_resp = 2'd2; rready = 1'b1; #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_pause_ack", pause_ack, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    req = 1'b0; r_valid = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Single write, AW accepted three cycles late, W immediately.
    req = 1'b1; we = 1'b1; addr = 32'h100; wdata = 32'hDEADBEEF; be = 4'hF; #1;
    chk("wr_gnt", gnt, 1);
    cycle();
    req = 1'b0; aw_ready = 1'b0; w_ready = 1'b1;
    chk("wr_aw_addr", aw_addr, 32'h100);
    chk("wr_w_data", w_data, 32'hDEADBEEF);
    cycle();
    w_ready = 1'b0;
    cycle(); cycle();
    aw_ready = 1'b1;
    cycle();
    aw_ready = 1'b0;
    chk("wr_aw_done", aw_valid, 0);
    b_valid = 1'b1; b_resp = 2'd0; #1;
    chk("wr_rvalid", rvalid, 1);
    chk("wr_err", err, 0);
    cycle();
    b_valid = 1'b0;
    cycle();
    chk("wr_aw_beats", n_aw, 1);
    chk("wr_w_beats", n_w, 1);
    chk("wr_responses", m_rsp, 1);

    // Back-to-back reads up to the outstanding limit.
    req = 1'b1; we = 1'b0; addr = 32'h40; ar_ready = 1'b1;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (last_gnt) grants++;
    end
    chk("rd_grants_at_limit", grants, 4);
    #1 chk("rd_gnt_full", gnt, 0);
    r_valid = 1'b1; r_data = 32'hA5A50001; r_resp = 2'd0; #1;
    chk("rd_gnt_rsp_cycle", gnt, 0);
    chk("rd_rdata", rdata, 32'hA5A50001);
    cycle();
    r_valid = 1'b0; #1;
    chk("rd_fifth_gnt", gnt, 1);
    cycle();
    if (last_gnt) grants++;
    budget = 60;
    while ((n_r < 6 || grants < 6) && budget > 0) begin
      req = (grants < 6);
      r_valid = (n_ar > n_r);
      r_data = $urandom;
      cycle();
      if (last_gnt) grants++;
      budget--;
    end
    req = 1'b0; r_valid = 1'b0;
    chk("rd_total_grants", grants, 6);
    chk("rd_total_responses", n_r, 6);

    // Direction change waits for the outstanding read.
    req = 1'b1; we = 1'b0; addr = 32'h80; #1;
    chk("dir_rd_gnt", gnt, 1);
    cycle();
    we = 1'b1; addr = 32'h84; wdata = 32'h11112222; be = 4'h3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dir_wr_blocked", gnt, 0);
      cycle();
    end
    r_valid = 1'b1; r_data = 32'h5; #1;
    chk("dir_wr_blocked_rsp", gnt, 0);
    cycle();
    r_valid = 1'b0; #1;
    chk("dir_wr_gnt", gnt, 1);
    cycle();
    drain();

    // Pause while two reads are outstanding.
    req = 1'b1; we = 1'b0; addr = 32'h300; ar_ready = 1'b1; rready = 1'b1;
    grants = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (last_gnt) grants++;
    end
    req = 1'b0;
    cycle();
    chk("pause_two_reads", grants, 2);
    pause_req = 1'b1;
    cycle();
    req = 1'b1; #1;
    chk("pause_drain_gnt", gnt, 0);
    r_valid = 1'b1; r_data = 32'h77;
    cycle();
    #1 chk("pause_ack_early", pause_ack, 0);
    cycle();
    r_valid = 1'b0; #1;
    chk("pause_ack_rise", pause_ack, 1);
    pause_req = 1'b0;
    cycle();
    #1 chk("pause_ack_fall", pause_ack, 0);
    req = 1'b0;

    // SLVERR read, then stray responses with nothing outstanding.
    req = 1'b1; we = 1'b0; addr = 32'h200;
    cycle();
    req = 1'b0;
    chk("err_ar_addr", ar_addr, 32'h200);
    cycle();
    r_valid = 1'b1; r_resp = 2'd2; r_data = 32'h12345678; #1;
    chk("err_rvalid", rvalid, 1);
    chk("err_err", err, 1);
    chk("err_rdata", rdata, 32'h12345678);
    cycle();
    r_data = 32'hFFFF; b_valid = 1'b1; #1;
    chk("idle_r_ready", r_ready, 0);
    chk("idle_rvalid", rvalid, 0);
    req = 1'b1; we = 1'b1; #1;
    chk("err_count_back_to_zero", gnt, 1);
    req = 1'b0; r_valid = 1'b0; b_valid = 1'b0;
    cycle();

    // Reset in the middle of a write.
    req = 1'b1; we = 1'b1; addr = 32'h500; wdata = 32'h1; aw_ready = 1'b0; w_ready = 1'b0;
    cycle();
    req = 1'b0;
    chk("rst_mid_aw_valid", aw_valid, 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst_mid_aw_clear", aw_valid, 0);
    chk("rst_mid_w_clear", w_valid, 0);
    chk("rst_mid_ar_clear", ar_valid, 0);
    chk("rst_mid_pause_ack", pause_ack, 1);
    cycle();
    req = 1'b1; we = 1'b0; #1;
    chk("rst_mid_count_zero", gnt, 1);
    req = 1'b0;
    cycle();

    // Random traffic against a random slave.
    for (int i = 0; i < 3000; i++) begin
      if (!req || last_gnt) begin
        req   = ($urandom % 3 != 0);
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        be    = 4'($urandom);
      end
      if ($urandom % 40 == 0) pause_req = !pause_req;
      rready = ($urandom % 4 != 0);
      slave_drive(1'b1);
      cycle();
    end
    pause_req = 1'b0;
    drain();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
